ex_unit: RTL
============

# ex_unit

Execute stage of the five-stage MIPS pipeline. Consumes the decoded operation (ALU opcode, two operands, destination and write-enable) that decode produces into the ID/EX register. Single-cycle ALU operations produce a same-cycle result. That result is also driven back to decode as the EX forwarding source. Signed and unsigned divide run on an internal 32-iteration restoring divider that stalls the pipeline and writes the internal HI/LO registers.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits, opcode 8 bits.
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- aluop_i  in  8  operation code from ID/EX register
- reg1_i  in  32  operand 1 (rs value, already forwarded)
- reg2_i  in  32  operand 2 (rt value or zero-extended immediate)
- wd_i  in  5  destination register index
- wreg_i  in  1  destination write enable
- flush_i  in  1  abort current instruction, including an in-flight divide
- wdata_o  out  32  result; also EX forwarding data to decode
- wd_o  out  5  destination index; also EX forwarding index
- wreg_o  out  1  write enable; also EX forwarding enable
- stall_o  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- Opcodes and wdata_o:
  - 0x00 NOP: forces wreg_o=0 and wdata_o=0.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
  - 0x21 ADDU, 0x23 SUBU: modulo 2^32, no overflow trap.
  - 0x2A SLT (signed), 0x2B SLTU: result 32'h1 or 32'h0.
  - 0x10 MFHI: returns HI. 0x12 MFLO: returns LO.
  - 0x1A DIV (signed), 0x1B DIVU: wdata_o=0, wreg_o=0; results go to HI/LO only.
- Any other opcode is treated as NOP.
- wd_o always equals wd_i. wreg_o equals wreg_i, except it is forced 0 for NOP, divide and unknown opcodes.
- Divider FSM states:
  - IDLE: on a DIV/DIVU op with no flush, latch operand magnitudes and sign info.
    - Divisor nonzero: go to BUSY with cnt=0.
    - Divisor zero: go to DONE with quotient=32'hFFFFFFFF and remainder=dividend (raw reg1_i).
  - BUSY: one restoring-division step per cycle (shift remainder left, subtract divisor, set quotient bit). cnt counts 0..31. Go to DONE after the step with cnt=31.
  - DONE: apply signs (DIV only). Quotient is negated when operand signs differ. Remainder takes the dividend's sign. On the edge leaving DONE, write LO=quotient and HI=remainder, then go to IDLE.
- The divide op stays on aluop_i during DONE; DONE must not restart it.
- stall_o = 1 in IDLE while a divide op is present, and throughout BUSY. stall_o = 0 in DONE, for non-divide ops, and whenever flush_i=1.
- flush_i=1 in any state: go to IDLE on the next edge, no HI/LO write. Same cycle: wreg_o=0, stall_o=0.
- DIV with dividend 32'h80000000 and divisor -1: quotient 32'h80000000, remainder 0 (wrap result, no trap).

## Timing
- While rst is low: FSM=IDLE, cnt=0, HI=LO=0, wdata_o=0, wd_o=0, wreg_o=0, stall_o=0.
- Reset asserted mid-divide aborts it immediately with no HI/LO write.
- Non-divide ops: zero latency; outputs are combinational from inputs and HI/LO.
- Divide, nonzero divisor, op first seen in cycle T:
  - stall_o high for cycles T..T+32 (33 cycles).
  - DONE occurs in cycle T+33.
  - HI/LO are updated at the end of T+33.
  - The next instruction enters EX in T+34, and MFHI/MFLO there returns the new values.
- Divide by zero: stall_o high for cycle T only; DONE in T+1; HI/LO updated at the end of T+1.
- Back-to-back divides: the second starts in the IDLE cycle after DONE, with no gap cycle lost.

## Test plan
- OR: reg1=32'h12340000, reg2=32'h0000FFFF, wd=5, wreg=1 -> wdata_o=32'h1234FFFF, wd_o=5, wreg_o=1, stall_o=0.
- SLT/SLTU: reg1=32'hFFFFFFFF, reg2=1 -> SLT gives 1, SLTU gives 0. SUBU 0-1 -> 32'hFFFFFFFF.
- DIVU 100/7 -> stall_o high exactly 33 cycles, then LO=14, HI=2; following MFLO gives 14 with wreg_o=1.
- DIV -7/2 (reg1=32'hFFFFFFF9, reg2=2) -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU 5/0 -> stall_o high 1 cycle, LO=32'hFFFFFFFF, HI=5.
- Abort cases, both starting from a DIVU 100/7 in flight with HI=LO=0 beforehand:
  - flush_i asserted at BUSY cnt=10 -> next cycle IDLE, stall_o=0, HI=LO unchanged (0).
  - rst pulled low at cnt=20 -> all outputs 0 immediately; after release, MFLO returns 0.

Source files
------------

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU with EX forwarding outputs, plus a
// 32-step restoring divider that stalls the pipeline and updates HI/LO.
module ex_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic        stall_o
);

  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } div_state_e;

  div_state_e  state;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dq;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        is_div;
  logic        is_sdiv;
  logic        dvs_zero;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        step_ge;
  logic [31:0] step_rem;
  logic [31:0] alu_res;
  logic        alu_wr;

  assign is_div   = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_sdiv  = (aluop_i == OP_DIV);
  assign dvs_zero = (reg2_i == '0);
  assign dvd_mag  = (is_sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
  assign dvs_mag  = (is_sdiv && reg2_i[31]) ? -reg2_i : reg2_i;

  // dq starts as the dividend and shifts quotient bits in from the right,
  // so after 32 steps it holds the unsigned quotient.
  assign trial    = {rem, dq[31]};
  assign diff     = trial - {1'b0, dvs};
  assign step_ge  = ~diff[32];
  assign step_rem = step_ge ? diff[31:0] : trial[31:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            cnt   <= '0;
            // Divide-by-zero results are raw, so sign fix-up is suppressed.
            neg_q <= is_sdiv && !dvs_zero && (reg1_i[31] ^ reg2_i[31]);
            neg_r <= is_sdiv && !dvs_zero && reg1_i[31];
            if (dvs_zero) begin
              dq    <= '1;
              rem   <= reg1_i;
              state <= S_DONE;
            end else begin
              dq    <= dvd_mag;
              rem   <= '0;
              dvs   <= dvs_mag;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          dq  <= {dq[30:0], step_ge};
          rem <= step_rem;
          if (cnt == 5'd31) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_DONE: begin
          lo    <= neg_q ? -dq : dq;
          hi    <= neg_r ? -rem : rem;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    case (aluop_i)
      OP_AND:  begin alu_res = reg1_i & reg2_i;    alu_wr = 1'b1; end
      OP_OR:   begin alu_res = reg1_i | reg2_i;    alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = reg1_i ^ reg2_i;    alu_wr = 1'b1; end
      OP_NOR:  begin alu_res = ~(reg1_i | reg2_i); alu_wr = 1'b1; end
      OP_ADDU: begin alu_res = reg1_i + reg2_i;    alu_wr = 1'b1; end
      OP_SUBU: begin alu_res = reg1_i - reg2_i;    alu_wr = 1'b1; end
      OP_SLT:  begin
        alu_res = {31'b0, ($signed(reg1_i) < $signed(reg2_i))};
        alu_wr  = 1'b1;
      end
      OP_SLTU: begin alu_res = {31'b0, (reg1_i < reg2_i)}; alu_wr = 1'b1; end
      OP_MFHI: begin alu_res = hi; alu_wr = 1'b1; end
      OP_MFLO: begin alu_res = lo; alu_wr = 1'b1; end
      default: begin alu_res = '0; alu_wr = 1'b0; end
    endcase
  end

  // Outputs are combinational; rst gating keeps them zero while in reset.
  assign wdata_o = rst ? alu_res : '0;
  assign wd_o    = rst ? wd_i : '0;
  assign wreg_o  = rst && !flush_i && wreg_i && alu_wr;
  assign stall_o = rst && !flush_i &&
                   (((state == S_IDLE) && is_div) || (state == S_BUSY));

endmodule
